// File: rtl/cp0_exc_if.sv
// EX-stage exception/CP0 access bundle between the pipeline and the CP0 exception handler.
interface cp0_exc_if #(
  parameter int unsigned IRQ_W = 6
);
  logic [1:0]       exc_code;
  logic             exc_valid;
  logic [31:0]      exc_pc;
  logic             eret;
  logic [IRQ_W-1:0] irq;
  logic             cp0_we;
  logic [4:0]       cp0_addr;
  logic [31:0]      cp0_wdata;
  logic [31:0]      cp0_rdata;
  logic             flush;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             exl;

  modport master (
    output exc_code, exc_valid, exc_pc, eret, irq, cp0_we, cp0_addr, cp0_wdata,
    input  cp0_rdata, flush, redirect, redirect_pc, exl
  );

  modport slave (
    input  exc_code, exc_valid, exc_pc, eret, irq, cp0_we, cp0_addr, cp0_wdata,
    output cp0_rdata, flush, redirect, redirect_pc, exl
  );
endinterface

// File: rtl/cp0_exc_handler.sv
// CP0 Status/Cause/EPC owner: takes sync exceptions, interrupts and ERET from the EX stage,
// then flushes the pipeline for one cycle while redirecting the PC.
module cp0_exc_handler #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned IRQ_W      = 6
) (
  input logic        clk,
  input logic        rst,
  cp0_exc_if.slave   bus
);
  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;
  localparam logic [4:0] CODE_RI     = 5'd10;
  localparam logic [4:0] CODE_OV     = 5'd12;
  localparam logic [4:0] CODE_INT    = 5'd0;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [IRQ_W-1:0] im_q, im_d;
  logic [IRQ_W-1:0] ip_q;
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [31:0]      epc_q, epc_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             pulse_q, pulse_d;
  logic [31:0]      rdata;

  logic sync_exc, intr_req, eret_req;

  assign sync_exc = bus.exc_valid && (bus.exc_code == 2'b01 || bus.exc_code == 2'b10);
  assign intr_req = bus.exc_valid && ie_q && !exl_q && (|(bus.irq & im_q));
  assign eret_req = bus.exc_valid && bus.eret;

  // State register; IP tracks the interrupt lines every cycle regardless of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      im_q          <= '0;
      ip_q          <= '0;
      ie_q          <= 1'b0;
      exl_q         <= 1'b0;
      exccode_q     <= '0;
      epc_q         <= '0;
      redirect_pc_q <= '0;
      pulse_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      im_q          <= im_d;
      ip_q          <= bus.irq;
      ie_q          <= ie_d;
      exl_q         <= exl_d;
      exccode_q     <= exccode_d;
      epc_q         <= epc_d;
      redirect_pc_q <= redirect_pc_d;
      pulse_q       <= pulse_d;
    end
  end

  // Next-state: one prioritized action per RUN cycle; FLUSH ignores squashed-instruction inputs.
  always_comb begin
    state_d       = state_q;
    im_d          = im_q;
    ie_d          = ie_q;
    exl_d         = exl_q;
    exccode_d     = exccode_q;
    epc_d         = epc_q;
    redirect_pc_d = redirect_pc_q;
    pulse_d       = 1'b0;

    case (state_q)
      RUN: begin
        if (sync_exc) begin
          exccode_d     = (bus.exc_code == 2'b01) ? CODE_RI : CODE_OV;
          if (!exl_q) epc_d = bus.exc_pc;
          exl_d         = 1'b1;
          redirect_pc_d = EXC_VECTOR;
          pulse_d       = 1'b1;
          state_d       = FLUSH;
        end else if (intr_req) begin
          exccode_d     = CODE_INT;
          epc_d         = bus.exc_pc;
          exl_d         = 1'b1;
          redirect_pc_d = EXC_VECTOR;
          pulse_d       = 1'b1;
          state_d       = FLUSH;
        end else if (eret_req) begin
          exl_d         = 1'b0;
          redirect_pc_d = epc_q;
          pulse_d       = 1'b1;
          state_d       = FLUSH;
        end else if (bus.cp0_we) begin
          case (bus.cp0_addr)
            ADDR_STATUS: begin
              im_d  = bus.cp0_wdata[10 +: IRQ_W];
              exl_d = bus.cp0_wdata[1];
              ie_d  = bus.cp0_wdata[0];
            end
            ADDR_EPC: epc_d = bus.cp0_wdata;
            default: ;
          endcase
        end
      end
      FLUSH: state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // MFC0 read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (bus.cp0_addr)
      ADDR_STATUS: begin
        rdata[10 +: IRQ_W] = im_q;
        rdata[1]           = exl_q;
        rdata[0]           = ie_q;
      end
      ADDR_CAUSE: begin
        rdata[10 +: IRQ_W] = ip_q;
        rdata[6:2]         = exccode_q;
      end
      ADDR_EPC: rdata = epc_q;
      default: ;
    endcase
  end

  assign bus.cp0_rdata   = rdata;
  assign bus.flush       = pulse_q;
  assign bus.redirect    = pulse_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.exl         = exl_q;
endmodule
